// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx through a start-pulse / busy-ack issue sequencer.
// Optional: define UART_TX_FIFO_CRLF_EN to send a CR (8'h0D) ahead of every LF (8'h0A).
module uart_tx_fifo #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [7:0]               uart_tx_data,
  output logic                     uart_tx_en,
  input  logic                     uart_tx_busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     fifo_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_ACK  = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   LVL_ONE = (AW + 1)'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(ACK_TIMEOUT);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic          in_ready_q;
  logic          tx_en_q;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;
  logic [7:0]    head;
`ifdef UART_TX_FIFO_CRLF_EN
  logic          cr_sent_q, cr_sent_d;
`endif

  assign push         = in_valid && in_ready_q;
  assign head         = mem[rd_ptr_q];
  assign in_ready     = in_ready_q;
  assign uart_tx_data = tx_data_q;
  assign uart_tx_en   = tx_en_q;
  assign fifo_level   = level_q;
  assign fifo_empty   = (level_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
    cr_sent_d = cr_sent_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !uart_tx_busy) begin
          state_d = ISSUE;
`ifdef UART_TX_FIFO_CRLF_EN
          // LF stays at the head while its CR goes out first
          if (head == 8'h0A && !cr_sent_q) begin
            tx_data_d = 8'h0D;
            cr_sent_d = 1'b1;
          end else begin
            pop       = 1'b1;
            tx_data_d = head;
            cr_sent_d = 1'b0;
          end
`else
          pop       = 1'b1;
          tx_data_d = head;
`endif
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (uart_tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ISSUE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (!push && pop) begin
      level_d = level_q - LVL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      in_ready_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_en_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      level_q    <= level_d;
      // DEPTH is a power of two, so the level MSB is set only when full
      in_ready_q <= ~level_d[AW];
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_en_q    <= (state_d == ISSUE);
    end
  end

`ifdef UART_TX_FIFO_CRLF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cr_sent_q <= 1'b0;
    end else begin
      cr_sent_q <= cr_sent_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: randomized pushes, a uart_tx busy model and a
// queue-based reference of bytes expected on the wire.
module tb_uart_tx_fifo;
  localparam int unsigned DEPTH       = 16;
  localparam int unsigned ACK_TIMEOUT = 15;

  logic                   clk = 1'b0;
  logic                   resetn = 1'b0;
  logic [7:0]             in_data = 8'h00;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [7:0]             uart_tx_data;
  logic                   uart_tx_en;
  logic                   uart_tx_busy;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   fifo_empty;

  logic busy_auto = 1'b0;
  logic busy_manual = 1'b0;
  logic busy_model = 1'b0;
  int   busy_hold = 20;

  assign uart_tx_busy = busy_auto ? busy_model : busy_manual;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DEPTH       (DEPTH),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .uart_tx_data (uart_tx_data),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_busy (uart_tx_busy),
    .fifo_level   (fifo_level),
    .fifo_empty   (fifo_empty)
  );

  typedef struct {
    logic [7:0] data;
    bit         pop;   // byte leaves the FIFO when it is first issued
  } exp_t;

  exp_t exp_q[$];
  int   pulse_cycles[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   pulse_count = 0;
  int   lvl_model = 0;
  bit   pend_push = 1'b0;
  bit   pending = 1'b0;
  int   base;
  int   n;
  bit   ok;
  logic [7:0] rb;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic exp_push(input logic [7:0] b);
    exp_t e;
`ifdef UART_TX_FIFO_CRLF_EN
    if (b == 8'h0A) begin
      e.data = 8'h0D;
      e.pop  = 1'b0;
      exp_q.push_back(e);
    end
`endif
    e.data = b;
    e.pop  = 1'b1;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; holds in_valid until the byte is taken at a clock edge.
  task automatic push_byte(input logic [7:0] b);
    int k = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && k < 5000) begin
      @(posedge clk); #1;
      k++;
    end
    check("push_accept", {31'd0, in_ready}, 32'd1);
    if (in_ready) exp_push(b);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string name);
    int k = 0;
    while (!(exp_q.size() == 0 && fifo_empty && !uart_tx_busy) && k < max) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, {31'd0, (k < max)}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
  endtask

  // uart_tx model: busy rises one edge after the start pulse and stays up busy_hold cycles.
  initial begin : busy_proc
    int  bcnt;
    bit  en_seen;
    bcnt = 0;
    forever begin
      @(negedge clk);
      en_seen = uart_tx_en;
      @(posedge clk); #1;
      if (!resetn || !busy_auto) begin
        busy_model = 1'b0;
        bcnt = 0;
      end else if (busy_model) begin
        bcnt--;
        if (bcnt <= 0) busy_model = 1'b0;
      end else if (en_seen) begin
        busy_model = 1'b1;
        bcnt = busy_hold;
      end
    end
  end

  // Monitor: a byte counts as delivered once busy rises after its pulse; re-pulses before that
  // must repeat the same byte.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!resetn) begin
        exp_q.delete();
        pending   = 1'b0;
        pend_push = 1'b0;
        lvl_model = 0;
        check("reset_en",    {31'd0, uart_tx_en}, 32'd0);
        check("reset_data",  {24'd0, uart_tx_data}, 32'd0);
        check("reset_level", 32'(fifo_level), 32'd0);
        check("reset_empty", {31'd0, fifo_empty}, 32'd1);
        check("reset_ready", {31'd0, in_ready}, 32'd1);
      end else begin
        if (pending && uart_tx_busy) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          pending = 1'b0;
        end
        lvl_model += int'(pend_push);
        if (uart_tx_en) begin
          pulse_count++;
          pulse_cycles.push_back(cycle);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: data %0h with nothing queued (cycle %0d)",
                     uart_tx_data, cycle);
          end else begin
            check("tx_data", {24'd0, uart_tx_data}, {24'd0, exp_q[0].data});
            if (!pending && exp_q[0].pop) lvl_model--;
            pending = 1'b1;
          end
        end
        check("fifo_level", 32'(fifo_level), 32'(lvl_model));
        check("in_ready",   {31'd0, in_ready}, {31'd0, (lvl_model < int'(DEPTH))});
        check("fifo_empty", {31'd0, fifo_empty}, {31'd0, (lvl_model == 0)});
        pend_push = in_valid && in_ready;
      end
    end
  end

  initial begin : main
    repeat (3) @(posedge clk);
    #1;
    check("init_en",    {31'd0, uart_tx_en}, 32'd0);
    check("init_level", 32'(fifo_level), 32'd0);
    check("init_ready", {31'd0, in_ready}, 32'd1);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Single byte: pulse visible in the cycle after the pop edge, i.e. sampled 2 edges on.
    busy_auto = 1'b1;
    busy_hold = 20;
    base = pulse_count;
    push_byte(8'h30);
    @(negedge clk);
    check("single_early_en", {31'd0, uart_tx_en}, 32'd0);
    @(negedge clk);
    check("single_pulse_en",   {31'd0, uart_tx_en}, 32'd1);
    check("single_pulse_data", {24'd0, uart_tx_data}, 32'h30);
    @(posedge clk); #1;
    wait_idle(2000, "single_drain");
    repeat (50) @(posedge clk);
    #1;
    check("single_pulse_count", 32'(pulse_count - base), 32'd1);

    // Burst to full while the transmitter is held busy, then a dropped 17th byte.
    busy_auto   = 1'b0;
    busy_manual = 1'b1;
    busy_hold   = 1250;
    base = pulse_count;
    for (int i = 0; i < 16; i++) push_byte(8'h30 + 8'(i));
    @(negedge clk);
    check("full_ready", {31'd0, in_ready}, 32'd0);
    check("full_level", 32'(fifo_level), 32'd16);
    @(posedge clk); #1;
    in_data  = 8'h40;
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("drop_level", 32'(fifo_level), 32'd16);
    @(posedge clk); #1;
    busy_manual = 1'b0;
    busy_auto   = 1'b1;
    wait_idle(30000, "burst_drain");
    check("burst_pulses", 32'(pulse_count - base), 32'd16);

    // Full with a pop: a held 8'hAA is taken only once in_ready returns.
    busy_auto   = 1'b0;
    busy_manual = 1'b1;
    busy_hold   = 30;
    for (int i = 0; i < 16; i++) push_byte(8'h50 + 8'(i));
    in_data  = 8'hAA;
    in_valid = 1'b1;
    busy_manual = 1'b0;
    busy_auto   = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("pop_ready_return", {31'd0, in_ready}, 32'd1);
    if (in_ready) exp_push(8'hAA);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("refill_level", 32'(fifo_level), 32'd16);
    @(posedge clk); #1;
    wait_idle(5000, "refill_drain");

    // Ack timeout: no busy response, so the same byte is re-pulsed.
    busy_auto   = 1'b0;
    busy_manual = 1'b0;
    base = pulse_count;
    pulse_cycles.delete();
    push_byte(8'h55);
    n = 0;
    while (pulse_cycles.size() < 3 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    busy_manual = 1'b1;
    check("retry_pulses_seen", {31'd0, (pulse_cycles.size() >= 3)}, 32'd1);
    if (pulse_cycles.size() >= 3) begin
      check("retry_gap1", 32'(pulse_cycles[1] - pulse_cycles[0]), ACK_TIMEOUT + 2);
      check("retry_gap2", 32'(pulse_cycles[2] - pulse_cycles[1]), ACK_TIMEOUT + 2);
    end
    push_byte(8'h66);
    repeat (30) @(posedge clk);
    #1;
    check("no_pop_while_busy", 32'(pulse_count - base), 32'd3);
    check("held_level", 32'(fifo_level), 32'd1);
    busy_manual = 1'b0;
    n = 0;
    while (pulse_count - base < 4 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    busy_manual = 1'b1;
    check("pop_after_busy_falls", 32'(pulse_count - base), 32'd4);
    repeat (3) @(posedge clk);
    #1;
    busy_manual = 1'b0;
    wait_idle(200, "timeout_drain");

    // Reset while the transmitter is busy with the first of three bytes.
    busy_auto = 1'b1;
    busy_hold = 50;
    push_byte(8'h71);
    push_byte(8'h72);
    push_byte(8'h73);
    n = 0;
    while (!uart_tx_busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("reset_busy_seen", {31'd0, uart_tx_busy}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_en",    {31'd0, uart_tx_en}, 32'd0);
    check("midrst_data",  {24'd0, uart_tx_data}, 32'd0);
    check("midrst_level", 32'(fifo_level), 32'd0);
    check("midrst_empty", {31'd0, fifo_empty}, 32'd1);
    check("midrst_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    base = pulse_count;
    repeat (100) @(posedge clk);
    #1;
    check("no_pulse_after_reset", 32'(pulse_count - base), 32'd0);

    // LF handling.
    busy_hold = 10;
    base = pulse_count;
    push_byte(8'h41);
    push_byte(8'h0A);
    wait_idle(2000, "crlf_drain");
`ifdef UART_TX_FIFO_CRLF_EN
    check("crlf_pulses", 32'(pulse_count - base), 32'd3);
`else
    check("crlf_pulses", 32'(pulse_count - base), 32'd2);
`endif

    // Randomized traffic with random transmitter hold times.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        rb = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom);
        busy_hold = int'($urandom_range(1, 30));
        push_byte(rb);
      end else begin
        @(posedge clk); #1;
      end
    end
    wait_idle(20000, "random_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer and issue sequencer directly upstream of uart_tx (8N1, pulse-start, busy-ack interface).
- Producers (keypad scanner, digit counters, message ROMs) push bytes with a valid/ready handshake.
- The block queues bytes in a FIFO and hands them to uart_tx one at a time, pulsing uart_tx_en and pacing on uart_tx_busy.
- Replaces free-running send timers, so no byte is dropped or sent twice.

Parameters:
- DEPTH, 16: FIFO entries; power of two, >= 2.
- ACK_TIMEOUT, 15: cycles to wait for uart_tx_busy to rise after a start pulse before re-pulsing; >= 2.

Ports:
- clk  in  1  system clock (12 MHz on icesugar_nano).
- resetn  in  1  asynchronous active-low reset.
- in_data  in  8  byte from producer.
- in_valid  in  1  producer has a byte.
- in_ready  out  1  FIFO can accept; high when level < DEPTH.
- uart_tx_data  out  8  byte to uart_tx.
- uart_tx_en  out  1  one-cycle start pulse to uart_tx.
- uart_tx_busy  in  1  transmitter busy, from uart_tx.
- fifo_level  out  $clog2(DEPTH)+1  entries currently stored.
- fifo_empty  out  1  level == 0.

Behaviour:
- Reset (async assert, sync release) clears the following:
  - pointers and level to 0; fifo_empty=1; in_ready=1;
  - uart_tx_en=0; uart_tx_data=8'h00; state=IDLE; timeout counter=0.
- Push: in_valid && in_ready at a rising edge writes in_data at wr_ptr and increments wr_ptr (wraps modulo DEPTH).
- Push timing: in_ready and fifo_level are registered and update the cycle after the push.
- Pop: occurs only in the IDLE->ISSUE transition. Pop latches mem[rd_ptr] into uart_tx_data and increments rd_ptr (wraps).
- Simultaneous push and pop: level is unchanged.
- Full FIFO: in_ready=0 and in_valid is ignored. A same-cycle pop does not raise in_ready early; in_ready rises the next cycle.
- Empty FIFO: no pop. A byte pushed into an empty FIFO reaches the uart_tx_en pulse two cycles after the push edge.
- State IDLE:
  - if !fifo_empty && !uart_tx_busy: pop, go to ISSUE.
  - otherwise stay.
- State ISSUE: uart_tx_en=1 for exactly this cycle; timeout counter cleared; go to WAIT_ACK.
- State WAIT_ACK:
  - uart_tx_busy=1: go to WAIT_DONE.
  - otherwise the counter increments; when it reaches ACK_TIMEOUT, go to ISSUE and re-pulse with the same byte (no new pop).
- State WAIT_DONE: when uart_tx_busy=0, go to IDLE. Minimum gap between successive pulses is therefore 3 cycles after busy falls.
- uart_tx_data stability: holds its value from ISSUE until the next pop.
- uart_tx_en is a registered output, high only in ISSUE.
- Reset mid-transfer: the FIFO contents are lost and the state machine returns to IDLE. uart_tx is reset by the same resetn.
- Illegal or unused state encodings recover to IDLE.

Optional Feature:
- Macro: UART_TX_FIFO_CRLF_EN.
- Defined:
  - When a popped byte is 8'h0A, the block first issues 8'h0D (full ISSUE/WAIT_ACK/WAIT_DONE cycle), then issues 8'h0A. The LF stays at the FIFO head until the CR completes.
  - A one-bit cr_sent flag, cleared on reset and after the LF issues, prevents repeating the CR.
  - The flag is preserved across timeout retries.
- Undefined: all bytes are passed through unmodified; no extra logic.

Test Plan:
- Single byte: after reset, push 8'h30 -> uart_tx_en pulses once 2 cycles later with uart_tx_data=8'h30; fifo_level goes 1 then 0; no second pulse.
- Burst to full: DEPTH=16; push 8'h30..8'h3F with the busy model (busy 1 cycle after en, held 1250 cycles) -> in_ready=0 at level 16; a 17th push of 8'h40 is dropped; output order is 8'h30..8'h3F.
- Full with simultaneous pop: fill to 16, hold in_valid=1 with 8'hAA -> level stays 16 across the pop edge; 8'hAA is accepted only once in_ready returns.
- Ack timeout: busy held at 0 -> uart_tx_en re-pulses every ACK_TIMEOUT+2 cycles with the same byte; releasing busy after the 3rd pulse -> no pop until busy falls.
- Reset mid-operation: push 3 bytes, assert resetn=0 during WAIT_DONE -> outputs go to reset values immediately; after release, no pulses occur with the FIFO empty.
- CRLF (UART_TX_FIFO_CRLF_EN defined): push 8'h41, 8'h0A -> pulses carry 8'h41, 8'h0D, 8'h0A. Undefined: pulses carry 8'h41, 8'h0A.
